// File: rtl/io_periph_pkg.sv
// Shared state encodings and default sizing for the io_peripheral slice.
package io_periph_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_OFFER    = 2'd1,
        TX_WAIT_LOW = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_RDY = 1'b0,
        RX_ACK = 1'b1
    } rx_state_t;
endpackage

// File: rtl/io_peripheral_fifo.sv
// Synchronous FIFO with full/empty/count; head visible combinationally from storage.
module io_fifo
    import io_periph_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/io_peripheral.sv
// Byte-wide 4-phase handshake peripheral with TX/RX FIFOs.
// Optional ack-wait timeout on TX enabled by defining IO_PERIPH_TIMEOUT_EN.
module io_peripheral
    import io_periph_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = 255
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             src_wr,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_full,
    output logic [WIDTH-1:0] input_bus,
    output logic             in_dev_hs,
    input  logic             in_dev_ack,
    input  logic [WIDTH-1:0] output_bus,
    input  logic             out_dev_req,
    output logic             out_dev_hs,
    output logic             out_dev_ack,
    input  logic             sink_rd,
    output logic [WIDTH-1:0] sink_data,
    output logic             sink_valid,
    output logic             tx_timeout
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_chk
        $error("io_peripheral: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    tx_state_t        tx_state;
    rx_state_t        rx_state, rx_nxt;
    logic [WIDTH-1:0] tx_head;
    logic             tx_empty, tx_rd, rx_wr, rx_empty, rx_full, to_hit;
    logic [AW:0]      tx_count, rx_count, rx_count_next;
    logic             unused_fifo;

    assign unused_fifo = ^{tx_count, rx_full};

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(g_clk), .rst_n(g_clr), .wr(src_wr), .wdata(src_data), .rd(tx_rd),
        .rdata(tx_head), .full(src_full), .empty(tx_empty), .count(tx_count)
    );

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(g_clk), .rst_n(g_clr), .wr(rx_wr), .wdata(output_bus), .rd(sink_rd),
        .rdata(sink_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign sink_valid = !rx_empty;
    assign tx_rd      = (tx_state == TX_OFFER) && in_dev_ack;
    assign rx_wr      = (rx_state == RX_RDY) && out_dev_hs && out_dev_req;

`ifdef IO_PERIPH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_flag;

    assign to_hit     = (tx_state == TX_OFFER) && !in_dev_ack && (to_cnt == TW'(TIMEOUT - 1));
    assign tx_timeout = to_flag;

    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (tx_state == TX_OFFER && !in_dev_ack && !to_hit) to_cnt <= to_cnt + 1'b1;
            else to_cnt <= '0;
            if (to_hit) to_flag <= 1'b1;
        end
    end
`else
    assign to_hit     = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            tx_state  <= TX_IDLE;
            in_dev_hs <= 1'b0;
            input_bus <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (!tx_empty) begin
                    input_bus <= tx_head;
                    in_dev_hs <= 1'b1;
                    tx_state  <= TX_OFFER;
                end
                TX_OFFER: if (in_dev_ack) begin
                    in_dev_hs <= 1'b0;
                    tx_state  <= TX_WAIT_LOW;
                end else if (to_hit) begin
                    // give up on this offer; head stays queued for a retry
                    in_dev_hs <= 1'b0;
                    tx_state  <= TX_IDLE;
                end
                TX_WAIT_LOW: if (!in_dev_ack) tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_nxt = rx_state;
        if (rx_wr) rx_nxt = RX_ACK;
        else if (rx_state == RX_ACK && !out_dev_req) rx_nxt = RX_RDY;
        rx_count_next = rx_count + (AW+1)'(rx_wr) - (AW+1)'(sink_rd && !rx_empty);
    end

    // out_dev_hs is registered, so derive it from next state and next occupancy
    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            rx_state    <= RX_RDY;
            out_dev_ack <= 1'b0;
            out_dev_hs  <= 1'b0;
        end else begin
            rx_state    <= rx_nxt;
            out_dev_ack <= (rx_nxt == RX_ACK);
            out_dev_hs  <= (rx_nxt == RX_RDY) && (rx_count_next != (AW+1)'(DEPTH));
        end
    end
endmodule

// File: doc/io_peripheral.md
IO_PERIPHERAL -- requirements
Module: io_peripheral

Interface
REQ-001 Parameter: WIDTH, 8, data bus width in bits.
REQ-002 Parameter: DEPTH, 4, entries per FIFO; power of 2, minimum 2.
REQ-003 Parameter: TIMEOUT, 255, ack-wait cycle limit; used only under IO_PERIPH_TIMEOUT_EN.
REQ-004 Port: g_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: g_clr  in  1  reset; synchronous, active-low.
REQ-006 Port: src_wr, src_data  in  1, WIDTH  bench/host push into TX FIFO.
REQ-007 Port: src_full  out  1  TX FIFO full.
REQ-008 Port: input_bus  out  WIDTH  byte offered to processor.
REQ-009 Port: in_dev_hs  out  1  offered byte valid.
REQ-010 Port: in_dev_ack  in  1  processor has taken the byte.
REQ-011 Port: output_bus  in  WIDTH  byte driven by processor.
REQ-012 Port: out_dev_req  in  1  processor output byte valid.
REQ-013 Port: out_dev_hs  out  1  peripheral ready to receive.
REQ-014 Port: out_dev_ack  out  1  peripheral has captured the byte.
REQ-015 Port: sink_rd  in  1; sink_data  out  WIDTH; sink_valid  out  1  RX FIFO head pop interface.
REQ-016 Port: tx_timeout  out  1  sticky timeout flag; tied 0 without the macro.

Function
REQ-017 TX FSM states: TX_IDLE, TX_OFFER, TX_WAIT_LOW; 4-phase handshake.
REQ-018 TX_IDLE with TX FIFO non-empty: next edge loads head into input_bus, sets in_dev_hs=1, enters TX_OFFER.
REQ-019 TX_OFFER: input_bus held stable; on in_dev_ack=1 sampled, in_dev_hs=0 next edge, head popped, enters TX_WAIT_LOW.
REQ-020 TX_WAIT_LOW: stays until in_dev_ack=0 sampled, then TX_IDLE; minimum back-to-back spacing is 1 idle cycle.
REQ-021 input_bus retains last offered byte outside TX_OFFER.
REQ-022 RX FSM states: RX_RDY, RX_ACK.
REQ-023 out_dev_hs is registered and equals 1 iff the RX FSM is in RX_RDY and the RX FIFO is not full.
REQ-024 RX_RDY with out_dev_hs=1 and out_dev_req=1 sampled: output_bus pushed to RX FIFO, out_dev_ack=1 and out_dev_hs=0 next edge, enters RX_ACK.
REQ-025 out_dev_req while the RX FIFO is full is ignored: no capture and no ack until space frees.
REQ-026 RX_ACK: on out_dev_req=0 sampled, out_dev_ack=0 next edge, enters RX_RDY.
REQ-027 FIFOs: src_wr when full is dropped; sink_rd when empty is ignored; simultaneous push and pop in one cycle are both honoured with count unchanged; pointers wrap modulo DEPTH.
REQ-028 sink_data/sink_valid show the RX FIFO head combinationally from registered storage; pop takes effect on the edge.

Reset
REQ-029 g_clr=0 at an edge, in any state: both FIFOs emptied, FSMs go to TX_IDLE/RX_RDY, in_dev_hs=0, out_dev_ack=0, input_bus=0, tx_timeout=0, timeout counter=0.
REQ-030 A handshake interrupted by reset is abandoned; the byte is lost.
REQ-031 out_dev_hs=1 on the first edge after reset release.

Configuration
REQ-032 Macro IO_PERIPH_TIMEOUT_EN, when defined: counter runs in TX_OFFER; after TIMEOUT cycles without ack, in_dev_hs=0, byte not popped, tx_timeout set sticky, return to TX_IDLE and retry.
REQ-033 Without IO_PERIPH_TIMEOUT_EN: TX_OFFER waits indefinitely, no counter logic, tx_timeout constant 0.

Structure
REQ-034 Package io_periph_pkg holds TX/RX state encodings plus default WIDTH and DEPTH constants.
REQ-035 One sub-module io_fifo (synchronous, parameterised WIDTH/DEPTH, full/empty/count outputs) is instantiated twice: TX and RX.

Verification
REQ-036 Push 0x3C, 0xA5; processor acks each after 2 cycles -> input_bus shows 0x3C then 0xA5, in_dev_hs pulses twice, src_full=0.
REQ-037 Push 5 bytes with DEPTH=4 and no ack -> src_full=1 after the 4th byte, 5th byte dropped, only 4 bytes are ever offered.
REQ-038 Processor sends 0x11, 0x22, 0x33, 0x44 with no sink_rd -> 4 acks, out_dev_hs=0; a 5th request gets no ack; after one sink_rd it is captured, and the FIFO drains in order 0x11, 0x22, 0x33, 0x44, 0x55.
REQ-039 g_clr=0 in TX_OFFER and in RX_ACK -> next edge: in_dev_hs=0, out_dev_ack=0, sink_valid=0, src_full=0.
REQ-040 IO_PERIPH_TIMEOUT_EN with TIMEOUT=10, no ack -> in_dev_hs drops after 10 cycles, tx_timeout=1, the same byte is re-offered; a later ack pops it.
